inj_scheduler: RTL and testbench
================================

Name: inj_scheduler

Overview:
- Sequences fuel-injector pulses for N_CH channels from the shared engine-phase tracker.
- Holds a configuration register file written by the host interface: pulse width in clk cycles, plus a start phase per channel.
- Sequential mode fires each channel once per engine cycle at its own start phase. Batch mode fires all channels together twice per engine cycle.
- Owns the pulse timing and the fault flagging for the injector output stage.

Parameters:
- N_CH, 4, number of injector channels (1..6).
- PHASE_MAX, 719, last eng_phase value of one engine cycle; phase wraps to 0 after it.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- en  in  1  global injection enable
- sync_valid  in  1  engine position is known
- trigger  in  1  one-cycle strobe marking a new eng_phase value
- eng_phase  in  16  current engine phase, 0..PHASE_MAX
- mode  in  1  0 = batch, 1 = sequential
- cfg_we  in  1  config write strobe
- cfg_addr  in  3  config register address
- cfg_wdata  in  32  config write data
- inj_out  out  N_CH  injector drive, bit i = channel i
- busy  out  N_CH  channel i pulse in progress (equals inj_out)
- overlap_err  out  1  sticky flag: a start request hit a channel that was already on

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - pw = 0; all start_phase = 0.
  - Every channel goes to IDLE.
  - inj_out = 0, busy = 0, overlap_err = 0.
- Config registers (write takes effect at the clk edge where cfg_we = 1):
  - addr 0: pw = cfg_wdata[31:0].
  - addr 1..N_CH: start_phase[addr-1] = cfg_wdata[15:0].
  - addr 7: clears overlap_err; data is ignored.
  - Any other address: write is ignored.
  - No readback.
- Start qualification: start_ok = trigger & en & sync_valid & (pw != 0).
- Sequential mode (mode = 1): channel i starts when start_ok and eng_phase == start_phase[i].
- Batch mode (mode = 0):
  - HALF = (PHASE_MAX+1)/2; p2 = (start_phase[0] + HALF) mod (PHASE_MAX+1).
  - All channels start when start_ok and eng_phase equals start_phase[0] or p2.
  - start_phase[1..] are ignored.
- A start_phase value > PHASE_MAX never matches, so the channel never fires. This is legal, not an error.
- Per-channel state machine, states IDLE and ON, with a 32-bit cycle counter cnt:
  - IDLE to ON on start: latch pw_lat = pw, cnt = 1; inj_out[i] goes high at that same clock edge.
  - In ON, each cycle: if cnt == pw_lat, go to IDLE (inj_out[i] low at that edge); otherwise cnt = cnt + 1.
  - Result: inj_out[i] is high for exactly pw_lat clk cycles. Latency from the start-qualifying input edge to inj_out high is 1 cycle.
- Start while ON: the request is ignored, the current pulse continues unchanged, and overlap_err is set.
- Simultaneous events:
  - Same-cycle pw write and start: the start latches the old pw.
  - Same-cycle addr-7 clear and new overlap: overlap_err stays 1 (set wins).
  - A channel ending (cnt == pw_lat) in the same cycle a start matches: the start is an overlap; the channel goes IDLE and overlap_err is set.
- A pw write during ON does not alter the pulse in progress.
- en = 0 or sync_valid = 0, sampled at a clk edge:
  - Every ON channel aborts to IDLE at that edge (inj_out low).
  - No starts occur.
  - overlap_err is unchanged.
- Mode change mid-pulse: pulses in progress complete normally; the new mode applies to the next start.
- Phase wrap needs no special handling beyond the mod in the p2 computation.
- Counter width is 32 bits. pw = 0xFFFF_FFFF is legal; cnt never exceeds pw_lat, so it never wraps.

Test Plan:
- Sequential timing: N_CH = 4, pw = 10, start_phase = {0, 180, 360, 540}, trigger each phase step 0..719.
  - Required: each inj_out[i] rises 1 cycle after its matching trigger edge and stays high exactly 10 cycles.
  - Required: no overlap_err.
- Batch mode: mode = 0, start_phase[0] = 100.
  - Required: all 4 outputs fire together at phase 100 and at phase 460.
  - Repeat with start_phase[0] = 600: firings at 600 and at 240 (wrap case).
- Overlap: pw = 5000 with start_phase[0] = 0, and phase triggers arriving faster than 5000 clk cycles per engine cycle.
  - Required: a second match while ON sets overlap_err; the first pulse still lasts exactly 5000 cycles.
  - Required: an addr-7 write clears the flag.
- Abort: during an ON pulse of pw = 100, drop sync_valid at cycle 40.
  - Required: inj_out is low from that edge on.
  - Required: re-asserting sync_valid does not resume the aborted pulse; only a new phase match starts a pulse.
- Config race: pw = 20, and a write of pw = 50 lands in the same cycle as a start.
  - Required: that pulse lasts 20 cycles; the next pulse lasts 50.
  - pw = 0: no pulses at all.
- Reset mid-pulse: assert rst_n = 0 for 1 cycle at ON cycle 3.
  - Required: inj_out = 0 and overlap_err = 0 the next cycle.
  - Required: no firing until pw is rewritten, because pw resets to 0.

Source files
------------

// File: rtl/inj_scheduler_if.sv
// ---------------------------------------------------------------------------
// inj_scheduler_if
// Bundles the control, configuration and injector-drive signals of the
// injector scheduler so the host/engine side and the scheduler share one
// connection.
//
// Signals:
//   en          global injection enable
//   sync_valid  engine position is known
//   trigger     one-cycle strobe marking a new eng_phase value
//   eng_phase   current engine phase
//   mode        0 = batch, 1 = sequential
//   cfg_we      config write strobe
//   cfg_addr    config register address
//   cfg_wdata   config write data
//   inj_out     injector drive, bit i = channel i
//   busy        channel i pulse in progress
//   overlap_err sticky overlap flag
//
// Modports: master drives control/config and observes outputs,
//           slave is the scheduler side.
// ---------------------------------------------------------------------------
interface inj_scheduler_if #(
   parameter int N_CH = 4
);
   logic              en;
   logic              sync_valid;
   logic              trigger;
   logic [15:0]       eng_phase;
   logic              mode;
   logic              cfg_we;
   logic [2:0]        cfg_addr;
   logic [31:0]       cfg_wdata;
   logic [N_CH-1:0]   inj_out;
   logic [N_CH-1:0]   busy;
   logic              overlap_err;

   modport master (
      output en, sync_valid, trigger, eng_phase, mode,
             cfg_we, cfg_addr, cfg_wdata,
      input  inj_out, busy, overlap_err
   );

   modport slave (
      input  en, sync_valid, trigger, eng_phase, mode,
             cfg_we, cfg_addr, cfg_wdata,
      output inj_out, busy, overlap_err
   );
endinterface

// File: rtl/inj_scheduler.sv
// ---------------------------------------------------------------------------
// inj_scheduler
// Sequences fuel-injector pulses for N_CH channels from the shared engine
// phase tracker. A small config register file holds the pulse width and a
// start phase per channel. Sequential mode fires each channel at its own
// start phase once per engine cycle; batch mode fires all channels together
// at start_phase[0] and half an engine cycle later.
//
// Ports:
//   clk    system clock
//   rst_n  synchronous reset, active low
//   bus    inj_scheduler_if.slave (control, config, inj_out/busy/overlap_err)
//
// Config map (write only):
//   0       pulse width in clk cycles
//   1..N_CH start phase of channel addr-1 (bits 15:0)
//   7       clear overlap_err
// ---------------------------------------------------------------------------
module inj_scheduler #(
   parameter int N_CH      = 4,
   parameter int PHASE_MAX = 719
) (
   input  logic               clk,
   input  logic               rst_n,
   inj_scheduler_if.slave     bus
);

   typedef enum logic {
      IDLE = 1'b0,
      ON   = 1'b1
   } chState_e;

   localparam int          PHASE_MOD   = PHASE_MAX + 1;
   localparam int          HALF        = PHASE_MOD / 2;
   localparam logic [16:0] PHASE_MOD17 = 17'(PHASE_MOD);
   localparam logic [16:0] HALF17      = 17'(HALF);
   localparam logic [15:0] PHASE_MAX16 = 16'(PHASE_MAX);

   logic [31:0] pw_q;
   logic [15:0] startPhase_q [N_CH];
   chState_e    state_q      [N_CH];
   logic [31:0] pwLat_q      [N_CH];
   logic [31:0] cnt_q        [N_CH];
   logic        overlapErr_q;

   logic            runOk;
   logic            startOk;
   logic [16:0]     p2Sum;
   logic [15:0]     p2;
   logic            batchHit;
   logic [N_CH-1:0] startReq;
   logic [N_CH-1:0] onMask;
   logic            overlapHit;

   // Decide which channels are asked to start this cycle. Batch mode uses
   // start_phase[0] and the point half an engine cycle away (wrapped), and a
   // start phase beyond the engine cycle can never match in either mode.
   // A request landing on a channel that is already ON is an overlap.
   always_comb begin
      runOk    = bus.en & bus.sync_valid;
      startOk  = bus.trigger & runOk & (pw_q != 32'd0);
      p2Sum    = {1'b0, startPhase_q[0]} + HALF17;
      p2       = (p2Sum >= PHASE_MOD17) ? 16'(p2Sum - PHASE_MOD17) : p2Sum[15:0];
      batchHit = (startPhase_q[0] <= PHASE_MAX16) &&
                 ((bus.eng_phase == startPhase_q[0]) || (bus.eng_phase == p2));
      startReq = '0;
      onMask   = '0;
      for (int i = 0; i < N_CH; i++) begin
         onMask[i] = (state_q[i] == ON);
         if (bus.mode) begin
            startReq[i] = startOk && (startPhase_q[i] <= PHASE_MAX16) &&
                          (bus.eng_phase == startPhase_q[i]);
         end else begin
            startReq[i] = startOk && batchHit;
         end
      end
      overlapHit = |(startReq & onMask);
   end

   // Config writes, the sticky overlap flag and every channel's IDLE/ON
   // state machine live here. The overlap set is written after the clear so
   // a same-cycle set wins. Losing en or sync_valid aborts every pulse; a
   // start latches the pw value from before any same-cycle pw write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pw_q         <= 32'd0;
         overlapErr_q <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            startPhase_q[i] <= 16'd0;
            state_q[i]      <= IDLE;
            pwLat_q[i]      <= 32'd0;
            cnt_q[i]        <= 32'd0;
         end
      end else begin
         if (bus.cfg_we) begin
            if (bus.cfg_addr == 3'd0) begin
               pw_q <= bus.cfg_wdata;
            end
            for (int i = 0; i < N_CH; i++) begin
               if (bus.cfg_addr == 3'(i + 1)) begin
                  startPhase_q[i] <= bus.cfg_wdata[15:0];
               end
            end
            if (bus.cfg_addr == 3'd7) begin
               overlapErr_q <= 1'b0;
            end
         end
         if (overlapHit) begin
            overlapErr_q <= 1'b1;
         end

         for (int i = 0; i < N_CH; i++) begin
            if (!runOk) begin
               state_q[i] <= IDLE;
            end else begin
               case (state_q[i])
                  IDLE: begin
                     if (startReq[i]) begin
                        state_q[i] <= ON;
                        pwLat_q[i] <= pw_q;
                        cnt_q[i]   <= 32'd1;
                     end
                  end
                  ON: begin
                     if (cnt_q[i] == pwLat_q[i]) begin
                        state_q[i] <= IDLE;
                     end else begin
                        cnt_q[i] <= cnt_q[i] + 32'd1;
                     end
                  end
                  default: state_q[i] <= IDLE;
               endcase
            end
         end
      end
   end

   // Outputs come straight from registered state, so they are glitch-free.
   always_comb begin
      bus.inj_out     = onMask;
      bus.busy        = onMask;
      bus.overlap_err = overlapErr_q;
   end

endmodule

// File: tb/tb_inj_scheduler.sv
// ---------------------------------------------------------------------------
// tb_inj_scheduler
// Directed bench for inj_scheduler with N_CH = 4, PHASE_MAX = 719. Each task
// covers one feature and compares against hand-computed values. A small
// edge monitor records, per channel, how many pulses rose, the phase that
// raised the first and last pulse, and the length of the last pulse.
// ---------------------------------------------------------------------------
module tb_inj_scheduler;

   localparam int N_CH = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   inj_scheduler_if #(.N_CH(N_CH)) bus();

   inj_scheduler #(.N_CH(N_CH), .PHASE_MAX(719)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int nChecks = 0;
   int nPass   = 0;

   int riseCnt   [N_CH];
   int firstRise [N_CH];
   int lastRise  [N_CH];
   int curLen    [N_CH];
   int lastLen   [N_CH];
   logic [N_CH-1:0] prevOut;

   // Clear the pulse monitor; only called while outputs are quiet.
   task automatic resetMon();
      for (int i = 0; i < N_CH; i++) begin
         riseCnt[i]   = 0;
         firstRise[i] = -1;
         lastRise[i]  = -1;
         curLen[i]    = 0;
         lastLen[i]   = 0;
      end
      prevOut = bus.inj_out;
   endtask

   // Drive one cycle's trigger/phase, step past the clock edge, then sample
   // the outputs and update the monitor. Strobes are dropped afterwards.
   task automatic applyStimulus(input logic trig, input int phase);
      bus.trigger   = trig;
      bus.eng_phase = 16'(phase);
      @(posedge clk);
      #1;
      for (int i = 0; i < N_CH; i++) begin
         if (bus.inj_out[i] && !prevOut[i]) begin
            riseCnt[i]++;
            if (firstRise[i] < 0) firstRise[i] = phase;
            lastRise[i] = phase;
            curLen[i]   = 1;
         end else if (bus.inj_out[i]) begin
            curLen[i]++;
         end else if (prevOut[i]) begin
            lastLen[i] = curLen[i];
         end
      end
      prevOut     = bus.inj_out;
      bus.trigger = 1'b0;
      bus.cfg_we  = 1'b0;
   endtask

   task automatic cfgWrite(input logic [2:0] addr, input logic [31:0] data);
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = addr;
      bus.cfg_wdata = data;
      applyStimulus(1'b0, 0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 0);
   endtask

   task automatic sweep();
      for (int p = 0; p <= 719; p++) applyStimulus(1'b1, p);
   endtask

   // Reset values of every output.
   task automatic test_reset();
      rst_n          = 1'b0;
      bus.en         = 1'b1;
      bus.sync_valid = 1'b1;
      bus.mode       = 1'b1;
      bus.cfg_we     = 1'b0;
      bus.cfg_addr   = 3'd0;
      bus.cfg_wdata  = 32'd0;
      bus.trigger    = 1'b0;
      bus.eng_phase  = 16'd0;
      prevOut        = '0;
      idle(2);
      nChecks++;
      if (bus.inj_out !== 4'b0000) $display("[TB] FAIL reset_inj_out: got %b expected 0000", bus.inj_out);
      else nPass++;
      nChecks++;
      if (bus.busy !== 4'b0000) $display("[TB] FAIL reset_busy: got %b expected 0000", bus.busy);
      else nPass++;
      nChecks++;
      if (bus.overlap_err !== 1'b0) $display("[TB] FAIL reset_overlap: got %b expected 0", bus.overlap_err);
      else nPass++;
      rst_n = 1'b1;
      resetMon();
   endtask

   // Sequential mode: each channel fires once at its own phase for pw cycles.
   task automatic test_sequential();
      cfgWrite(3'd0, 32'd10);
      cfgWrite(3'd1, 32'd0);
      cfgWrite(3'd2, 32'd180);
      cfgWrite(3'd3, 32'd360);
      cfgWrite(3'd4, 32'd540);
      bus.mode = 1'b1;
      resetMon();
      sweep();
      idle(20);
      for (int i = 0; i < N_CH; i++) begin
         nChecks++;
         if (riseCnt[i] !== 1) $display("[TB] FAIL seq_count[%0d]: got %0d expected 1", i, riseCnt[i]);
         else nPass++;
         nChecks++;
         if (firstRise[i] !== 180 * i) $display("[TB] FAIL seq_phase[%0d]: got %0d expected %0d", i, firstRise[i], 180 * i);
         else nPass++;
         nChecks++;
         if (lastLen[i] !== 10) $display("[TB] FAIL seq_width[%0d]: got %0d expected 10", i, lastLen[i]);
         else nPass++;
      end
      nChecks++;
      if (bus.overlap_err !== 1'b0) $display("[TB] FAIL seq_overlap: got %b expected 0", bus.overlap_err);
      else nPass++;
   endtask

   // Batch mode: all channels fire at start_phase[0] and half a cycle later.
   task automatic test_batch();
      int expFirst [2];
      int expLast  [2];
      int sp0      [2];
      sp0[0] = 100; expFirst[0] = 100; expLast[0] = 460;
      sp0[1] = 600; expFirst[1] = 240; expLast[1] = 600;
      bus.mode = 1'b0;
      for (int r = 0; r < 2; r++) begin
         cfgWrite(3'd1, 32'(sp0[r]));
         resetMon();
         sweep();
         idle(20);
         for (int i = 0; i < N_CH; i++) begin
            nChecks++;
            if (riseCnt[i] !== 2) $display("[TB] FAIL batch_count[%0d] sp0=%0d: got %0d expected 2", i, sp0[r], riseCnt[i]);
            else nPass++;
            nChecks++;
            if (firstRise[i] !== expFirst[r]) $display("[TB] FAIL batch_first[%0d] sp0=%0d: got %0d expected %0d", i, sp0[r], firstRise[i], expFirst[r]);
            else nPass++;
            nChecks++;
            if (lastRise[i] !== expLast[r]) $display("[TB] FAIL batch_last[%0d] sp0=%0d: got %0d expected %0d", i, sp0[r], lastRise[i], expLast[r]);
            else nPass++;
         end
      end
      bus.mode = 1'b1;
   endtask

   // A match while ON is ignored but flagged; addr 7 clears the flag.
   task automatic test_overlap();
      cfgWrite(3'd0, 32'd5000);
      cfgWrite(3'd1, 32'd0);
      cfgWrite(3'd2, 32'd800);
      cfgWrite(3'd3, 32'd800);
      cfgWrite(3'd4, 32'd800);
      resetMon();
      sweep();
      nChecks++;
      if (bus.overlap_err !== 1'b0) $display("[TB] FAIL ovl_before: got %b expected 0", bus.overlap_err);
      else nPass++;
      applyStimulus(1'b1, 0);
      nChecks++;
      if (bus.overlap_err !== 1'b1) $display("[TB] FAIL ovl_set: got %b expected 1", bus.overlap_err);
      else nPass++;
      idle(4400);
      nChecks++;
      if (lastLen[0] !== 5000) $display("[TB] FAIL ovl_width: got %0d expected 5000", lastLen[0]);
      else nPass++;
      nChecks++;
      if (riseCnt[0] !== 1) $display("[TB] FAIL ovl_count: got %0d expected 1", riseCnt[0]);
      else nPass++;
      nChecks++;
      if (riseCnt[1] + riseCnt[2] + riseCnt[3] !== 0) $display("[TB] FAIL ovl_outofrange: got %0d expected 0", riseCnt[1] + riseCnt[2] + riseCnt[3]);
      else nPass++;
      cfgWrite(3'd7, 32'hFFFF_FFFF);
      nChecks++;
      if (bus.overlap_err !== 1'b0) $display("[TB] FAIL ovl_clear: got %b expected 0", bus.overlap_err);
      else nPass++;
   endtask

   // Dropping sync_valid aborts the pulse; only a new match restarts one.
   task automatic test_abort();
      cfgWrite(3'd0, 32'd100);
      resetMon();
      applyStimulus(1'b1, 0);
      idle(39);
      bus.sync_valid = 1'b0;
      applyStimulus(1'b0, 0);
      nChecks++;
      if (bus.inj_out !== 4'b0000) $display("[TB] FAIL abort_low: got %b expected 0000", bus.inj_out);
      else nPass++;
      bus.sync_valid = 1'b1;
      idle(5);
      applyStimulus(1'b1, 5);
      nChecks++;
      if (bus.inj_out !== 4'b0000) $display("[TB] FAIL abort_noresume: got %b expected 0000", bus.inj_out);
      else nPass++;
      bus.en = 1'b0;
      applyStimulus(1'b1, 0);
      nChecks++;
      if (bus.inj_out !== 4'b0000) $display("[TB] FAIL abort_en_off: got %b expected 0000", bus.inj_out);
      else nPass++;
      bus.en = 1'b1;
      applyStimulus(1'b1, 0);
      nChecks++;
      if (bus.busy !== 4'b0001) $display("[TB] FAIL abort_restart: got %b expected 0001", bus.busy);
      else nPass++;
      idle(110);
      nChecks++;
      if (lastLen[0] !== 100) $display("[TB] FAIL abort_full_width: got %0d expected 100", lastLen[0]);
      else nPass++;
      nChecks++;
      if (bus.overlap_err !== 1'b0) $display("[TB] FAIL abort_overlap: got %b expected 0", bus.overlap_err);
      else nPass++;
   endtask

   // A pw write racing a start: the start keeps the old width. pw = 0 blocks.
   task automatic test_config_race();
      cfgWrite(3'd0, 32'd20);
      resetMon();
      bus.cfg_we    = 1'b1;
      bus.cfg_addr  = 3'd0;
      bus.cfg_wdata = 32'd50;
      applyStimulus(1'b1, 0);
      idle(30);
      nChecks++;
      if (lastLen[0] !== 20) $display("[TB] FAIL race_old_pw: got %0d expected 20", lastLen[0]);
      else nPass++;
      applyStimulus(1'b1, 0);
      idle(60);
      nChecks++;
      if (lastLen[0] !== 50) $display("[TB] FAIL race_new_pw: got %0d expected 50", lastLen[0]);
      else nPass++;
      cfgWrite(3'd0, 32'd0);
      resetMon();
      applyStimulus(1'b1, 0);
      applyStimulus(1'b1, 0);
      idle(3);
      nChecks++;
      if (riseCnt[0] !== 0) $display("[TB] FAIL pw_zero: got %0d expected 0", riseCnt[0]);
      else nPass++;
   endtask

   // Reset during a pulse clears outputs, the flag, pw and start phases.
   task automatic test_reset_mid_pulse();
      cfgWrite(3'd0, 32'd10);
      applyStimulus(1'b1, 0);
      applyStimulus(1'b1, 0);
      nChecks++;
      if (bus.overlap_err !== 1'b1) $display("[TB] FAIL rst_pre_overlap: got %b expected 1", bus.overlap_err);
      else nPass++;
      applyStimulus(1'b0, 0);
      rst_n = 1'b0;
      applyStimulus(1'b0, 0);
      rst_n = 1'b1;
      nChecks++;
      if (bus.inj_out !== 4'b0000) $display("[TB] FAIL rst_mid_out: got %b expected 0000", bus.inj_out);
      else nPass++;
      nChecks++;
      if (bus.overlap_err !== 1'b0) $display("[TB] FAIL rst_mid_overlap: got %b expected 0", bus.overlap_err);
      else nPass++;
      applyStimulus(1'b1, 0);
      applyStimulus(1'b1, 0);
      nChecks++;
      if (bus.inj_out !== 4'b0000) $display("[TB] FAIL rst_pw_cleared: got %b expected 0000", bus.inj_out);
      else nPass++;
      cfgWrite(3'd0, 32'd3);
      applyStimulus(1'b1, 0);
      nChecks++;
      if (bus.inj_out !== 4'b1111) $display("[TB] FAIL rst_phase_cleared: got %b expected 1111", bus.inj_out);
      else nPass++;
   endtask

   initial begin
      $display("[TB] inj_scheduler bench start");
      test_reset();
      test_sequential();
      test_batch();
      test_overlap();
      test_abort();
      test_config_race();
      test_reset_mid_pulse();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
